soc_noc_echo_responder: RTL

SOC_NOC_ECHO_RESPONDER -- requirements
Module: soc_noc_echo_responder

---
 rtl/soc_noc_echo_responder_if.sv | 24 ++
 rtl/soc_noc_echo_responder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/soc_noc_echo_responder_if.sv
// Flit handshake bundle between a tile and the echo responder.
// slave is the responder side, master is the tile side.
interface soc_noc_echo_responder_if #(
    parameter int FLIT_WIDTH = 32
);
    logic [FLIT_WIDTH-1:0] in_flit;
    logic                  in_last;
    logic                  in_valid;
    logic                  in_ready;
    logic [FLIT_WIDTH-1:0] out_flit;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready;

    modport slave (
        input  in_flit, in_last, in_valid, out_ready,
        output in_ready, out_flit, out_last, out_valid
    );

    modport master (
        output in_flit, in_last, in_valid, out_ready,
        input  in_ready, out_flit, out_last, out_valid
    );
endinterface

// File: rtl/soc_noc_echo_responder.sv
// Store-and-forward NoC echo responder: buffers one packet, swaps dest/src in the header, sends it back.
// Optional packet/drop statistics counters are built when SOC_NOC_ECHO_STATS_EN is defined.
module soc_noc_echo_responder #(
    parameter int FLIT_WIDTH  = 32,
    parameter int MAX_PKT_LEN = 8,
    parameter int DEST_MSB    = 31,
    parameter int SRC_MSB     = 23
) (
    input  logic                     clk,
    input  logic                     rst_n,
    soc_noc_echo_responder_if.slave  noc,
    output logic [15:0]              pkt_count,
    output logic [15:0]              drop_count
);
    localparam int CW = $clog2(MAX_PKT_LEN + 1);
    localparam int AW = $clog2(MAX_PKT_LEN);

    typedef enum logic [1:0] {IDLE, RECV, DROP, SEND} state_t;

    state_t                state_q;
    logic [CW-1:0]         wr_cnt_q;
    logic [CW-1:0]         rd_cnt_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic [FLIT_WIDTH-1:0] out_flit_q;
    logic [FLIT_WIDTH-1:0] buf_q [MAX_PKT_LEN];

    logic          in_fire;
    logic          out_fire;
    logic [CW-1:0] wr_cnt_inc;
    logic [CW-1:0] rd_cnt_inc;

    assign in_fire    = noc.in_valid && in_ready_q;
    assign out_fire   = out_valid_q && noc.out_ready;
    assign wr_cnt_inc = wr_cnt_q + 1'b1;
    assign rd_cnt_inc = rd_cnt_q + 1'b1;

    function automatic logic [FLIT_WIDTH-1:0] swap_hdr(input logic [FLIT_WIDTH-1:0] f);
        logic [FLIT_WIDTH-1:0] r;
        r = f;
        r[DEST_MSB -: 5] = f[SRC_MSB -: 5];
        r[SRC_MSB -: 5]  = f[DEST_MSB -: 5];
        return r;
    endfunction

    // NOTE: the flit store has no reset so it maps onto plain RAM; stale words are never read
    // because rd_cnt_q stays below wr_cnt_q.
    always_ff @(posedge clk) begin
        if (in_fire && (state_q == IDLE || state_q == RECV))
            buf_q[wr_cnt_q[AW-1:0]] <= noc.in_flit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_flit_q  <= '0;
        end else begin
            case (state_q)
                IDLE, RECV: begin
                    in_ready_q <= 1'b1;
                    if (in_fire) begin
                        wr_cnt_q <= wr_cnt_inc;
                        if (noc.in_last) begin
                            // The header of a single-flit packet is still on the input, not yet in the store.
                            state_q     <= SEND;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= (wr_cnt_q == '0);
                            out_flit_q  <= swap_hdr((wr_cnt_q == '0) ? noc.in_flit : buf_q[0]);
                        end else if (wr_cnt_inc == CW'(MAX_PKT_LEN)) begin
                            state_q <= DROP;
                        end else begin
                            state_q <= RECV;
                        end
                    end
                end
                DROP: begin
                    if (in_fire && noc.in_last) begin
                        state_q  <= IDLE;
                        wr_cnt_q <= '0;
                    end
                end
                SEND: begin
                    if (out_fire) begin
                        if (out_last_q) begin
                            state_q     <= IDLE;
                            wr_cnt_q    <= '0;
                            rd_cnt_q    <= '0;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            out_flit_q  <= '0;
                        end else begin
                            rd_cnt_q   <= rd_cnt_inc;
                            out_flit_q <= buf_q[rd_cnt_inc[AW-1:0]];
                            out_last_q <= (rd_cnt_inc == wr_cnt_q - 1'b1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign noc.in_ready  = in_ready_q;
    assign noc.out_valid = out_valid_q;
    assign noc.out_last  = out_last_q;
    assign noc.out_flit  = out_flit_q;

`ifdef SOC_NOC_ECHO_STATS_EN
    logic [15:0] pkt_count_q;
    logic [15:0] drop_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            if (state_q == SEND && out_fire && out_last_q)
                pkt_count_q <= pkt_count_q + 16'd1;
            if (state_q == DROP && in_fire && noc.in_last)
                drop_count_q <= drop_count_q + 16'd1;
        end
    end

    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;
`else
    assign pkt_count  = 16'd0;
    assign drop_count = 16'd0;
`endif
endmodule
